// File: rtl/imem_banked_fetch_if.sv
// imem_banked_fetch_if
//   Fetch/loader bus between the IF stage (master) and the instruction
//   memory (slave).
//   Fetch request : req_valid, req_ready, req_addr
//   Fetch response: rsp_valid, rsp_ready, rsp_data, rsp_err
//   Redirect      : flush
//   Loader        : ld_we, ld_addr, ld_data
//   Status        : busy (memory is sweeping after reset)
interface imem_banked_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              flush;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, ld_we, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, ld_we, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/imem_banked_fetch.sv
// imem_banked_fetch
//   Loadable synchronous instruction memory for the IF stage. Fetches use a
//   valid/ready request/response handshake with one cycle of latency; flush
//   drops a held response for branch redirects. After each reset a hardware
//   sweep writes NOP_WORD to every word, then the program is written through
//   the loader port.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : imem_banked_fetch_if.slave (fetch request/response, flush,
//          loader write port, busy status)
module imem_banked_fetch #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 256,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h00400000,
    parameter logic [DATA_W-1:0]  NOP_WORD  = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_banked_fetch_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_sweep_idx;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode. The extra top bit of the difference is the borrow,
    // so it flags addresses below BASE_ADDR. BASE_ADDR is aligned to
    // 4*DEPTH, so diff[1:0] equals addr[1:0].
    // ------------------------------------------------------------------
    logic [ADDR_W:0]   w_req_diff;
    logic [ADDR_W:0]   w_ld_diff;
    logic              w_req_legal;
    logic              w_ld_legal;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_ld_idx;

    assign w_req_diff  = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    assign w_ld_diff   = {1'b0, bus.ld_addr}  - {1'b0, BASE_ADDR};

    assign w_req_legal = ~w_req_diff[ADDR_W]
                       & (w_req_diff[ADDR_W-1:IDX_W+2] == '0)
                       & (w_req_diff[1:0] == 2'b00);
    assign w_ld_legal  = ~w_ld_diff[ADDR_W]
                       & (w_ld_diff[ADDR_W-1:IDX_W+2] == '0)
                       & (w_ld_diff[1:0] == 2'b00);

    assign w_req_idx   = w_req_diff[IDX_W+1:2];
    assign w_ld_idx    = w_ld_diff[IDX_W+1:2];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_run;
    logic w_req_ready;
    logic w_accept;
    logic w_ld_fire;

    assign w_run       = (r_state == ST_RUN);
    assign w_req_ready = w_run & ~bus.flush & (~r_rsp_valid | bus.rsp_ready);
    assign w_accept    = w_req_ready & bus.req_valid;
    assign w_ld_fire   = w_run & bus.ld_we & w_ld_legal;

    // ------------------------------------------------------------------
    // Memory write port: the sweep owns it in SWEEP, the loader in RUN.
    // While rst is held the sweep rewrites word 0 with NOP_WORD, which the
    // restarted sweep would do anyway.
    // ------------------------------------------------------------------
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_widx;
    logic [DATA_W-1:0] w_mem_wdata;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_widx  = r_sweep_idx;
        w_mem_wdata = NOP_WORD;
        if (r_state == ST_SWEEP) begin
            w_mem_we = 1'b1;
        end else if (w_ld_fire) begin
            w_mem_we    = 1'b1;
            w_mem_widx  = w_ld_idx;
            w_mem_wdata = bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_widx] <= w_mem_wdata;
    end

    // Write-first: a load landing on the fetched word this same edge wins.
    logic [DATA_W-1:0] w_rd_word;
    assign w_rd_word = (w_ld_fire && (w_ld_idx == w_req_idx)) ? bus.ld_data
                                                              : r_mem[w_req_idx];

    // ------------------------------------------------------------------
    // Sweep FSM and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= NOP_WORD;
            r_rsp_err   <= 1'b0;
        end else begin
            if (r_state == ST_SWEEP) begin
                r_sweep_idx <= r_sweep_idx + 1'b1;
                if (r_sweep_idx == IDX_W'(DEPTH - 1))
                    r_state <= ST_RUN;
            end

            // flush wins over everything; req_ready is already low then.
            if (bus.flush) begin
                r_rsp_valid <= 1'b0;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_req_legal ? w_rd_word : NOP_WORD;
                r_rsp_err   <= ~w_req_legal;
            end else if (bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state == ST_SWEEP);

endmodule

// File: tb/tb_imem_banked_fetch.sv
module tb_imem_banked_fetch;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h00400000;
    localparam logic [31:0] NOP   = 32'h00000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_banked_fetch_if #(.ADDR_W(32), .DATA_W(32)) f ();

    imem_banked_fetch #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(f)
    );

    logic        rv = 0, rr = 0, fl = 0, lw = 0;
    logic [31:0] ra = 0, la = 0, ld = 0;
    assign f.req_valid = rv;
    assign f.req_addr  = ra;
    assign f.rsp_ready = rr;
    assign f.flush     = fl;
    assign f.ld_we     = lw;
    assign f.ld_addr   = la;
    assign f.ld_data   = ld;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [31:0] mem_m [DEPTH];
    logic [32:0] q [$];          // {err, data}
    bit          run_m;
    int          sweep_cnt;
    bit          exp_vld;

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_m = 0;
        sweep_cnt = 0;
        exp_vld = 0;
        q.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    endtask

    // One clock: check outputs against the model with the inputs already
    // driven, advance the model, then cross the edge.
    task automatic cyc();
        bit exp_rdy;
        #1;
        exp_rdy = run_m && !rst && !fl && (!exp_vld || rr);
        chk("busy", {31'd0, f.busy}, {31'd0, !run_m});
        chk("req_ready", {31'd0, f.req_ready}, {31'd0, exp_rdy});
        chk("rsp_valid", {31'd0, f.rsp_valid}, {31'd0, exp_vld});
        if (exp_vld) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                chk("rsp_data", f.rsp_data, q[0][31:0]);
                chk("rsp_err", {31'd0, f.rsp_err}, {31'd0, q[0][32]});
            end
        end
        if (!rst) begin
            if (run_m && lw && legal(la)) mem_m[widx(la)] = ld;
            if (fl) begin
                if (exp_vld && q.size() > 0) void'(q.pop_front());
                exp_vld = 0;
            end else begin
                if (exp_vld && rr && q.size() > 0) void'(q.pop_front());
                if (exp_rdy && rv) begin
                    q.push_back(legal(ra) ? {1'b0, mem_m[widx(ra)]} : {1'b1, NOP});
                    exp_vld = 1;
                end else if (rr) begin
                    exp_vld = 0;
                end
            end
        end
        @(posedge clk);
        if (!run_m && !rst) begin
            sweep_cnt++;
            if (sweep_cnt == DEPTH) run_m = 1;
        end
        #1;
    endtask

    task automatic idle();
        rv = 0; fl = 0; lw = 0;
    endtask

    task automatic sweep();
        for (int i = 0; i < DEPTH; i++) begin
            // loader writes during the sweep must be ignored
            lw = (i >= DEPTH - 3); la = BASE; ld = 32'h11111111;
            cyc();
        end
        lw = 0;
    endtask

    initial begin
        model_reset();
        #2 rst = 1;
        #1;
        chk("reset_rsp_valid", {31'd0, f.rsp_valid}, 32'd0);
        chk("reset_rsp_data", f.rsp_data, NOP);
        chk("reset_rsp_err", {31'd0, f.rsp_err}, 32'd0);
        chk("reset_busy", {31'd0, f.busy}, 32'd1);
        cyc(); cyc();
        rst = 0;

        // T1: sweep then fetch every word
        sweep();
        rr = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rv = 1; ra = BASE + 32'(4 * i);
            cyc();
        end
        idle(); cyc();

        // T2: load two words, fetch back to back
        lw = 1; la = BASE + 4;  ld = 32'h3c011001; cyc();
        lw = 1; la = BASE + 8;  ld = 32'h343d0004; cyc();
        lw = 0;
        rv = 1; ra = BASE + 4; cyc();
        rv = 1; ra = BASE + 8; cyc();
        idle(); cyc();

        // T3: backpressure for 3 clocks, then handoff plus same-cycle accept
        rv = 1; ra = BASE + 4; rr = 0; cyc();
        ra = BASE + 8;
        repeat (3) cyc();
        rr = 1; cyc();
        idle(); cyc();

        // T4: misaligned and out-of-range fetch, illegal load
        rv = 1; ra = BASE + 2; cyc();
        rv = 1; ra = BASE + 32'h40; lw = 1; la = BASE + 32'h40; ld = 32'hBADBAD00; cyc();
        lw = 0;
        rv = 1; ra = BASE - 4; cyc();
        rv = 1; ra = BASE; cyc();
        rv = 1; ra = BASE + 32'h3C; cyc();
        idle(); cyc();

        // T5: flush a held response, then write-first bypass
        rv = 1; ra = BASE + 8; rr = 0; cyc();
        rv = 0; cyc();
        rv = 1; ra = BASE + 4; fl = 1; cyc();
        fl = 0; rv = 0; cyc();
        rr = 1;
        rv = 1; ra = BASE + 32'h10; lw = 1; la = BASE + 32'h10; ld = 32'hDEADBEEF; cyc();
        lw = 0; rv = 1; ra = BASE + 32'h10; cyc();
        idle(); cyc();

        // T6: asynchronous reset with a response held
        rv = 1; ra = BASE + 4; rr = 0; cyc();
        rv = 0;
        #3 rst = 1;
        #1;
        chk("async_rst_rsp_valid", {31'd0, f.rsp_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, f.busy}, 32'd1);
        chk("async_rst_req_ready", {31'd0, f.req_ready}, 32'd0);
        model_reset();
        cyc();
        rst = 0;
        sweep();
        rr = 1;
        rv = 1; ra = BASE + 4;     cyc();
        rv = 1; ra = BASE + 8;     cyc();
        rv = 1; ra = BASE + 32'h10; cyc();
        rv = 1; ra = BASE;          cyc();
        idle(); cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
